// File: rtl/wave_pkg.sv
// Shared types and helpers for the polyphonic square-wave generator.
package wave_pkg;

   typedef enum logic [1:0] {StIdle, StAccum, StSat} mix_state_e;

   localparam int unsigned DEF_AMPLITUDE  = 32'd268435456;
   localparam int unsigned DEF_SAMPLE_DIV = 1042;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) result = i + 1;
      end
      return result;
   endfunction

   // Clamp a wide signed value into the signed range of a width-bit word.
   function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] value,
                                                    input int unsigned     width);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (width - 1));
      if (value > hi) return hi;
      if (value < lo) return lo;
      return value;
   endfunction

endpackage

// File: rtl/wave_voice.sv
// One gated square-wave voice: half-period counter, polarity and signed level.
module wave_voice
   import wave_pkg::*;
#(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned CNT_W     = 18,
   parameter int unsigned AMPLITUDE = DEF_AMPLITUDE
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     gate_i,
   input  logic [CNT_W-1:0]         half_period_i,
   output logic signed [DATA_W-1:0] level_o
);

   localparam logic signed [DATA_W-1:0] AmpPos = DATA_W'(AMPLITUDE);
   localparam logic signed [DATA_W-1:0] AmpNeg = -AmpPos;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pol_q, pol_d;
   logic             gate_q;
   logic             wrap;

   // cnt+1 >= half_period avoids underflow of half_period-1 and never wraps on a shrink.
   assign wrap = ({1'b0, cnt_q} + (CNT_W + 1)'(1)) >= {1'b0, half_period_i};

   always_comb begin
      cnt_d = cnt_q;
      pol_d = pol_q;
      if (!gate_i || !gate_q) begin
         cnt_d = '0;
         pol_d = 1'b0;
      end else if (wrap) begin
         cnt_d = '0;
         pol_d = ~pol_q;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q  <= '0;
         pol_q  <= 1'b0;
         gate_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         pol_q  <= pol_d;
         gate_q <= gate_i;
      end
   end

   always_comb begin
      level_o = '0;
      if (gate_q && (half_period_i >= CNT_W'(2))) level_o = pol_q ? AmpNeg : AmpPos;
   end

endmodule

// File: rtl/poly_wave_generator.sv
// Polyphonic square-wave source: voices, sample divider, sequential saturating mixer
// and audio-controller write handshake with overrun counting.
module poly_wave_generator
   import wave_pkg::*;
#(
   parameter int unsigned NUM_VOICES = 8,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned CNT_W      = 18,
   parameter int unsigned AMPLITUDE  = DEF_AMPLITUDE,
   parameter int unsigned SAMPLE_DIV = DEF_SAMPLE_DIV
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [NUM_VOICES-1:0]       gate,
   input  logic [NUM_VOICES*CNT_W-1:0] half_period,
   input  logic                        audio_out_allowed,
   output logic                        write_audio_out,
   output logic [DATA_W-1:0]           audio_out,
   output logic                        clear_audio_out_memory,
   output logic [15:0]                 overrun_count
);

   localparam int unsigned IDX_W = (clog2(NUM_VOICES) == 0) ? 1 : clog2(NUM_VOICES);
   localparam int unsigned ACC_W = DATA_W + clog2(NUM_VOICES) + 1;
   localparam int unsigned DIV_W = clog2(SAMPLE_DIV);

   logic signed [DATA_W-1:0] level [NUM_VOICES];
   logic signed [DATA_W-1:0] snap_q [NUM_VOICES];

   for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
      wave_voice #(
         .DATA_W    (DATA_W),
         .CNT_W     (CNT_W),
         .AMPLITUDE (AMPLITUDE)
      ) u_voice (
         .clk_i         (clock),
         .rst_i         (reset),
         .gate_i        (gate[i]),
         .half_period_i (half_period[i*CNT_W +: CNT_W]),
         .level_o       (level[i])
      );
   end

   logic [DIV_W-1:0]        div_q;
   logic                    tick;
   mix_state_e              state_q, state_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic                    snap_load, sat_fire;
   logic [DATA_W-1:0]       sample_q, out_q, sat_value;
   logic                    pending_q, pending_d, write_q, consume;
   logic [15:0]             overrun_q, overrun_d;
   logic                    gate_any_q, clr_q;

   assign tick      = (div_q == DIV_W'(SAMPLE_DIV - 1));
   assign sat_value = DATA_W'(sat_clamp(64'(acc_q), DATA_W));
   assign consume   = pending_q & audio_out_allowed;

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      idx_d     = idx_q;
      snap_load = 1'b0;
      sat_fire  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (tick) begin
               snap_load = 1'b1;
               acc_d     = '0;
               idx_d     = '0;
               state_d   = StAccum;
            end
         end
         StAccum: begin
            acc_d = acc_q + ACC_W'(snap_q[idx_q]);
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(NUM_VOICES - 1)) state_d = StSat;
         end
         StSat: begin
            sat_fire = 1'b1;
            state_d  = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // A new sample landing on the consume edge replaces the one being sent, without overrun.
   always_comb begin
      pending_d = pending_q;
      overrun_d = overrun_q;
      if (consume) pending_d = 1'b0;
      if (sat_fire) begin
         pending_d = 1'b1;
         if (pending_q && !consume && (overrun_q != 16'hFFFF)) overrun_d = overrun_q + 16'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         div_q      <= '0;
         state_q    <= StIdle;
         acc_q      <= '0;
         idx_q      <= '0;
         sample_q   <= '0;
         out_q      <= '0;
         pending_q  <= 1'b0;
         write_q    <= 1'b0;
         overrun_q  <= '0;
         gate_any_q <= 1'b0;
         clr_q      <= 1'b0;
         for (int i = 0; i < NUM_VOICES; i++) snap_q[i] <= '0;
      end else begin
         div_q      <= tick ? '0 : div_q + DIV_W'(1);
         state_q    <= state_d;
         acc_q      <= acc_d;
         idx_q      <= idx_d;
         pending_q  <= pending_d;
         overrun_q  <= overrun_d;
         write_q    <= consume;
         gate_any_q <= |gate;
         clr_q      <= gate_any_q & ~(|gate);
         if (consume)  out_q    <= sample_q;
         if (sat_fire) sample_q <= sat_value;
         if (snap_load) begin
            for (int i = 0; i < NUM_VOICES; i++) snap_q[i] <= level[i];
         end
      end
   end

   assign write_audio_out        = write_q;
   assign audio_out              = out_q;
   assign overrun_count          = overrun_q;
   assign clear_audio_out_memory = reset | clr_q;

endmodule

// File: tb/tb_poly_wave_generator.sv
// Directed bench for poly_wave_generator; two instances differ only in AMPLITUDE.
module tb_poly_wave_generator;

   localparam int NV    = 4;
   localparam int DW    = 16;
   localparam int CW    = 18;
   localparam int SD    = 16;
   localparam int AMP_A = 1000;
   localparam int AMP_B = 12288;
   localparam int NEVER = 1 << 30;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             allowed = 1'b1;
   logic [NV-1:0]    gate = '0;
   logic [NV*CW-1:0] half_period = '0;

   logic          wr_a, wr_b, clr_a, clr_b;
   logic [DW-1:0] out_a, out_b;
   logic [15:0]   ovr_a, ovr_b;

   int cyc = 0;
   int hp[NV];
   int g_on[NV];
   int g_off[NV];
   int q_a[$];
   int q_b[$];
   int n_assert = 0;
   int n_fail = 0;

   poly_wave_generator #(
      .NUM_VOICES (NV), .DATA_W (DW), .CNT_W (CW), .AMPLITUDE (AMP_A), .SAMPLE_DIV (SD)
   ) dut_a (
      .clock                  (clock),
      .reset                  (reset),
      .gate                   (gate),
      .half_period            (half_period),
      .audio_out_allowed      (allowed),
      .write_audio_out        (wr_a),
      .audio_out              (out_a),
      .clear_audio_out_memory (clr_a),
      .overrun_count          (ovr_a)
   );

   poly_wave_generator #(
      .NUM_VOICES (NV), .DATA_W (DW), .CNT_W (CW), .AMPLITUDE (AMP_B), .SAMPLE_DIV (SD)
   ) dut_b (
      .clock                  (clock),
      .reset                  (reset),
      .gate                   (gate),
      .half_period            (half_period),
      .audio_out_allowed      (allowed),
      .write_audio_out        (wr_b),
      .audio_out              (out_b),
      .clear_audio_out_memory (clr_b),
      .overrun_count          (ovr_b)
   );

   always #5 clock = ~clock;

   // cyc = number of rising edges since reset was released
   always @(posedge clock) cyc <= reset ? 0 : cyc + 1;

   // Expected mix of the levels present just after edge n.
   function automatic int model(input int n, input int amp);
      int s = 0;
      for (int v = 0; v < NV; v++) begin
         if (g_on[v] <= n && n < g_off[v] && hp[v] >= 2)
            s += (((n - g_on[v]) / hp[v]) % 2 != 0) ? -amp : amp;
      end
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      return s;
   endfunction

   task automatic check(input string tag, input logic signed [31:0] obs, input int exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic pop_check(input string tag, input logic [DW-1:0] obs, inout int q[$]);
      n_assert++;
      assert (q.size() != 0) else begin
         n_fail++;
         $error("FAIL %s: observed strobe at edge %0d, expected none", tag, cyc);
      end
      if (q.size() != 0) check(tag, $signed(obs), q.pop_front());
   endtask

   // Advance to the next falling edge, then score the sample stream.
   task automatic step();
      @(negedge clock);
      if (!reset) begin
         if (cyc > 0 && cyc % SD == 0) begin
            q_a.push_back(model(cyc - 1, AMP_A));
            q_b.push_back(model(cyc - 1, AMP_B));
         end
         if (wr_a === 1'b1) pop_check("sample_a", out_a, q_a);
         if (wr_b === 1'b1) pop_check("sample_b", out_b, q_b);
      end
   endtask

   task automatic wait_strobe(input int maxc, output int at);
      at = -1;
      for (int i = 0; i < maxc && at < 0; i++) begin
         step();
         if (wr_a === 1'b1) at = cyc;
      end
      n_assert++;
      assert (at >= 0) else begin
         n_fail++;
         $error("FAIL strobe_timeout: observed no strobe in %0d cycles, expected one", maxc);
      end
   endtask

   task automatic set_gate(input logic [NV-1:0] g);
      for (int v = 0; v < NV; v++) begin
         if (g[v] && !gate[v]) begin
            g_on[v]  = cyc + 1;
            g_off[v] = NEVER;
         end else if (!g[v] && gate[v]) begin
            g_off[v] = cyc + 1;
         end
      end
      gate = g;
   endtask

   task automatic set_hp(input int v, input int val);
      hp[v] = val;
      half_period[v*CW +: CW] = CW'(val);
   endtask

   initial begin
      int at, at2, s;
      for (int v = 0; v < NV; v++) begin
         hp[v]    = 0;
         g_on[v]  = NEVER;
         g_off[v] = NEVER;
      end

      // Reset and first strobe
      repeat (5) begin
         step();
         check("clear_in_reset", clr_a, 1);
      end
      check("reset_write", wr_a, 0);
      check("reset_audio_out", $signed(out_a), 0);
      check("reset_overrun", ovr_a, 0);
      reset = 1'b0;
      step();
      check("clear_after_reset", clr_a, 0);
      wait_strobe(40, at);
      check("first_strobe_edge", at, SD + 6);

      // Single voice, then a second voice at a different pitch
      set_hp(0, 4);
      set_gate(4'b0001);
      repeat (3 * SD) step();
      wait_strobe(40, at);
      wait_strobe(40, at2);
      check("sample_period", at2 - at, SD);
      set_hp(1, 5);
      set_gate(4'b0011);
      repeat (6 * SD) step();

      // Gates released: FIFO clear pulse, then silence
      set_gate(4'b0000);
      step();
      check("clear_pulse", clr_a, 1);
      step();
      check("clear_pulse_end", clr_a, 0);
      repeat (3 * SD) step();

      // All voices in phase; instance B saturates
      for (int v = 0; v < NV; v++) set_hp(v, 3);
      set_gate(4'b1111);
      repeat (8 * SD) step();

      // Half-period of 1 silences a gated voice
      set_hp(2, 1);
      repeat (4 * SD) step();

      // Controller stalls for 40 edges covering three mixer results
      wait_strobe(40, s);
      check("overrun_before", ovr_a, 0);
      repeat (14) step();
      allowed = 1'b0;
      repeat (40) step();
      allowed = 1'b1;
      check("overrun_a", ovr_a, 2);
      check("overrun_b", ovr_b, 2);
      repeat (2) begin
         if (q_a.size() != 0) q_a.delete(0);
         if (q_b.size() != 0) q_b.delete(0);
      end
      wait_strobe(4, at);
      check("resume_strobe_edge", at, s + 55);
      repeat (2 * SD) step();
      check("overrun_final", ovr_a, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
